score_display_driver: RTL and testbench

Drives the 4-digit, 7-segment display on the game board. It converts the 6-bit score and the 6-bit seconds-remaining value to BCD with a sequential double-dabble engine. It then time-multiplexes the four digits using the 1 kHz display clock from the clock divider. It sits downstream of `score_counter` and the countdown timer, on the output side of the top level.

---
 rtl/score_display_driver_if.sv | 22 ++
 rtl/score_display_driver.sv | 159 +++++++++++++++
 tb/tb_score_display_driver.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/score_display_driver_if.sv
// rtl/score_display_driver_if.sv - display driver signal bundle
// The master drives the values to show and the scan clock. The slave drives the LED lines and busy.
interface score_display_driver_if;
  logic       scanClock;
  logic       displayOn;
  logic [5:0] score;
  logic [5:0] timeLeft;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] anode;
  logic       busy;

  modport master (
    output scanClock, displayOn, score, timeLeft,
    input  seg, dp, anode, busy
  );

  modport slave (
    input  scanClock, displayOn, score, timeLeft,
    output seg, dp, anode, busy
  );
endinterface

// File: rtl/score_display_driver.sv
// rtl/score_display_driver.sv - 4-digit 7-segment driver for score and time left
// A sequential double-dabble engine converts both values to BCD. The four digits are then multiplexed on scan-clock edges.
module score_display_driver #(
  parameter bit BLANK_LEADING = 1'b1
) (
  input logic                   clock,
  input logic                   reset,
  score_display_driver_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CONV_S, CONV_T, COMMIT} state_t;

  state_t      state_q, state_d;
  logic [5:0]  score_snap_q, score_snap_d, time_snap_q, time_snap_d;
  logic [5:0]  sh_q, sh_d;
  logic [7:0]  bcd_q, bcd_d, bcd_s_q, bcd_s_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] digits_q, digits_d;
  logic        busy_q, busy_d;
  logic [2:0]  sync_q, sync_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  anode_q, anode_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        scan_rise;
  logic [3:0]  cur_digit;

  function automatic logic [7:0] dabble(input logic [7:0] b, input logic in_bit);
    logic [7:0] a;
    a = b;
    if (a[3:0] >= 4'd5) a[3:0] = a[3:0] + 4'd3;
    if (a[7:4] >= 4'd5) a[7:4] = a[7:4] + 4'd3;
    return {a[6:0], in_bit};
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  // CONV_S spends its first cycle loading the shifter. Score's result is parked in bcd_s while timeLeft converts.
  always_comb begin
    state_d      = state_q;
    score_snap_d = score_snap_q;
    time_snap_d  = time_snap_q;
    sh_d         = sh_q;
    bcd_d        = bcd_q;
    bcd_s_d      = bcd_s_q;
    cnt_d        = cnt_q;
    digits_d     = digits_q;
    case (state_q)
      IDLE: begin
        if (bus.score != score_snap_q || bus.timeLeft != time_snap_q) begin
          score_snap_d = bus.score;
          time_snap_d  = bus.timeLeft;
          cnt_d        = 3'd0;
          state_d      = CONV_S;
        end
      end
      CONV_S: begin
        if (cnt_q == 3'd0) begin
          bcd_d = 8'd0;
          sh_d  = score_snap_q;
          cnt_d = 3'd1;
        end else if (cnt_q == 3'd6) begin
          bcd_s_d = dabble(bcd_q, sh_q[5]);
          bcd_d   = 8'd0;
          sh_d    = time_snap_q;
          cnt_d   = 3'd1;
          state_d = CONV_T;
        end else begin
          bcd_d = dabble(bcd_q, sh_q[5]);
          sh_d  = {sh_q[4:0], 1'b0};
          cnt_d = cnt_q + 3'd1;
        end
      end
      CONV_T: begin
        bcd_d = dabble(bcd_q, sh_q[5]);
        sh_d  = {sh_q[4:0], 1'b0};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd6) state_d = COMMIT;
      end
      COMMIT: begin
        digits_d = {bcd_q, bcd_s_q};
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign scan_rise = sync_q[1] & ~sync_q[2];
  assign cur_digit = digits_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    sync_d  = {sync_q[1:0], bus.scanClock};
    idx_d   = idx_q;
    anode_d = anode_q;
    seg_d   = seg_q;
    dp_d    = dp_q;
    if (scan_rise) begin
      idx_d   = idx_q + 2'd1;
      anode_d = bus.displayOn ? ~(4'b0001 << idx_q) : 4'hF;
      seg_d   = (BLANK_LEADING && idx_q[0] && cur_digit == 4'd0) ? 7'h7F : seg_of(cur_digit);
      dp_d    = (idx_q != 2'd2);
    end else if (!bus.displayOn) begin
      anode_d = 4'hF;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      score_snap_q <= '0;
      time_snap_q  <= '0;
      sh_q         <= '0;
      bcd_q        <= '0;
      bcd_s_q      <= '0;
      cnt_q        <= '0;
      digits_q     <= '0;
      busy_q       <= 1'b0;
      sync_q       <= '0;
      idx_q        <= '0;
      anode_q      <= 4'hF;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      score_snap_q <= score_snap_d;
      time_snap_q  <= time_snap_d;
      sh_q         <= sh_d;
      bcd_q        <= bcd_d;
      bcd_s_q      <= bcd_s_d;
      cnt_q        <= cnt_d;
      digits_q     <= digits_d;
      busy_q       <= busy_d;
      sync_q       <= sync_d;
      idx_q        <= idx_d;
      anode_q      <= anode_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.anode = anode_q;
  assign bus.seg   = seg_q;
  assign bus.dp    = dp_q;
endmodule

// File: tb/tb_score_display_driver.sv
// tb/tb_score_display_driver.sv - randomized self-checking bench for score_display_driver
// dut0 blanks leading zeros and dut1 does not. Both receive identical stimulus.
module tb_score_display_driver;
  logic       clk, rst_n, scan, disp_on;
  logic [5:0] sc, tl;
  int         checks, failures, exp_idx, com_s, com_t;
  logic [6:0] seg_tab [10];

  score_display_driver_if if0 ();
  score_display_driver_if if1 ();
  assign if0.scanClock = scan;
  assign if0.displayOn = disp_on;
  assign if0.score     = sc;
  assign if0.timeLeft  = tl;
  assign if1.scanClock = scan;
  assign if1.displayOn = disp_on;
  assign if1.score     = sc;
  assign if1.timeLeft  = tl;

  score_display_driver #(.BLANK_LEADING(1'b1)) dut0 (.clock(clk), .reset(rst_n), .bus(if0));
  score_display_driver #(.BLANK_LEADING(1'b0)) dut1 (.clock(clk), .reset(rst_n), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digits by plain division. The glyph comes from a table and the anode is a one-hot index.
  function automatic logic [11:0] exp_out(input bit blank, input int idx, input bit on);
    int v, d;
    logic [6:0] s;
    logic [3:0] a;
    v = (idx < 2) ? com_s : com_t;
    d = (idx % 2 == 0) ? v % 10 : v / 10;
    s = (idx % 2 == 1 && blank && d == 0) ? 7'h7F : seg_tab[d];
    a = on ? ~(4'b0001 << idx) : 4'hF;
    return {s, a, (idx == 2) ? 1'b0 : 1'b1};
  endfunction

  task automatic do_scan(output int ix, output logic [11:0] o0, output logic [11:0] o1);
    @(negedge clk) scan = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    o0 = {if0.seg, if0.anode, if0.dp};
    o1 = {if1.seg, if1.anode, if1.dp};
    ix = exp_idx;
    exp_idx = (exp_idx + 1) % 4;
    scan = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_idle();
    int k;
    repeat (2) @(posedge clk);
    #1;
    for (k = 0; k < 60 && (if0.busy || if1.busy); k++) begin
      @(posedge clk);
      #1;
    end
    if (k == 60) begin
      checks++; failures++;
      $display("FAIL wait_idle timeout busy0=%b busy1=%b required 0", if0.busy, if1.busy);
    end
    com_s = sc;
    com_t = tl;
  endtask

  task automatic align0();
    int ix;
    logic [11:0] o0, o1;
    while (exp_idx != 0) do_scan(ix, o0, o1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; scan = 1'b0; disp_on = 1'b1; sc = 6'd0; tl = 6'd0;
    exp_idx = 0; com_s = 0; com_t = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({if0.seg, if0.anode, if0.dp, if0.busy} !== {7'h7F, 4'hF, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs got seg=%b anode=%b dp=%b busy=%b", if0.seg, if0.anode, if0.dp, if0.busy);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (if0.busy !== 1'b0 || if1.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_zero_no_conv busy0=%b busy1=%b required 0", if0.busy, if1.busy);
    end
  endtask

  task automatic test_basic();
    int ix, c0, c1;
    logic [11:0] o0, o1;
    align0();
    @(negedge clk) begin sc = 6'd42; tl = 6'd59; end
    c0 = 0; c1 = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (if0.busy) c0++;
      if (if1.busy) c1++;
      if (!if0.busy && !if1.busy && c0 > 0) break;
    end
    checks++;
    if (c0 != 14 || c1 != 14) begin
      failures++;
      $display("FAIL basic_busy_len got %0d/%0d cycles required 14", c0, c1);
    end
    com_s = sc; com_t = tl;
    for (int i = 0; i < 4; i++) begin
      do_scan(ix, o0, o1);
      checks++;
      if (o0 !== exp_out(1, ix, 1) || o1 !== exp_out(0, ix, 1)) begin
        failures++;
        $display("FAIL basic_digit%0d got %h/%h required %h/%h", ix, o0, o1, exp_out(1, ix, 1), exp_out(0, ix, 1));
      end
    end
  endtask

  task automatic test_values(input int s, input int t, input string name);
    int ix;
    logic [11:0] o0, o1;
    @(negedge clk) begin sc = s[5:0]; tl = t[5:0]; end
    wait_idle();
    align0();
    for (int i = 0; i < 4; i++) begin
      do_scan(ix, o0, o1);
      checks++;
      if (o0 !== exp_out(1, ix, 1) || o1 !== exp_out(0, ix, 1)) begin
        failures++;
        $display("FAIL %s_digit%0d s=%0d t=%0d got %h/%h required %h/%h", name, ix, s, t, o0, o1, exp_out(1, ix, 1), exp_out(0, ix, 1));
      end
    end
  endtask

  task automatic test_blank();
    test_values(7, 0, "blank");
  endtask

  task automatic test_max();
    test_values(63, 63, "max");
  endtask

  task automatic test_midchange();
    int cnt, cnt2, ix;
    logic [11:0] o0, o1;
    align0();
    @(negedge clk) begin sc = 6'd10; tl = 6'd20; end
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (if0.busy) cnt++;
      if (cnt == 5 && if0.busy) sc = 6'd11;
      if (!if0.busy && cnt > 0) break;
    end
    checks++;
    if (cnt != 14) begin
      failures++;
      $display("FAIL mid_first_busy got %0d required 14", cnt);
    end
    com_s = 10; com_t = 20;
    scan = 1'b1;
    cnt2 = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        checks++;
        if (if0.busy !== 1'b1) begin
          failures++;
          $display("FAIL mid_gap busy=%b required 1 after one idle cycle", if0.busy);
        end
      end
      if (k == 2) begin
        o0 = {if0.seg, if0.anode, if0.dp};
        checks++;
        if (o0 !== exp_out(1, 0, 1)) begin
          failures++;
          $display("FAIL mid_first_commit got %h required %h", o0, exp_out(1, 0, 1));
        end
        exp_idx = 1;
        scan = 1'b0;
      end
      if (if0.busy) cnt2++;
      else if (k > 0) break;
    end
    checks++;
    if (cnt2 != 14) begin
      failures++;
      $display("FAIL mid_second_busy got %0d required 14", cnt2);
    end
    com_s = 11;
    repeat (3) @(posedge clk);
    align0();
    do_scan(ix, o0, o1);
    checks++;
    if (o0 !== exp_out(1, ix, 1)) begin
      failures++;
      $display("FAIL mid_second_commit got %h required %h", o0, exp_out(1, ix, 1));
    end
  endtask

  task automatic test_display_off();
    int ix;
    logic [11:0] o0, o1;
    @(negedge clk) disp_on = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_scan(ix, o0, o1);
      checks++;
      if (o0[4:1] !== 4'hF || o1[4:1] !== 4'hF) begin
        failures++;
        $display("FAIL dispoff_anode%0d got %b/%b required 1111", i, o0[4:1], o1[4:1]);
      end
    end
    @(negedge clk) disp_on = 1'b1;
    do_scan(ix, o0, o1);
    checks++;
    if (o0 !== exp_out(1, ix, 1) || o1 !== exp_out(0, ix, 1)) begin
      failures++;
      $display("FAIL dispoff_resume idx=%0d got %h/%h required %h/%h", ix, o0, o1, exp_out(1, ix, 1), exp_out(0, ix, 1));
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++)
      test_values(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), "rand");
  endtask

  task automatic test_reset_mid();
    int ix;
    logic [11:0] o0, o1;
    @(negedge clk) begin sc = sc ^ 6'd1; tl = tl ^ 6'd2; end
    repeat (5) @(posedge clk);
    #2;
    checks++;
    if (if0.busy !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pre_busy got %b required 1", if0.busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({if0.seg, if0.anode, if0.dp, if0.busy, if1.busy} !== {7'h7F, 4'hF, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL rstmid_async got seg=%b anode=%b dp=%b busy=%b required 1111111 1111 1 0", if0.seg, if0.anode, if0.dp, if0.busy);
    end
    @(negedge clk) rst_n = 1'b1;
    exp_idx = 0;
    wait_idle();
    do_scan(ix, o0, o1);
    checks++;
    if (o0 !== exp_out(1, ix, 1) || o0[4:1] !== 4'b1110) begin
      failures++;
      $display("FAIL rstmid_first_scan got %h required %h", o0, exp_out(1, 0, 1));
    end
  endtask

  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_blank();
    test_max();
    test_midchange();
    test_display_off();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
